// File: rtl/axi_lite_resp_timeout_pkg.sv
// Channel FSM encoding and default AXI4-Lite request/response structs for the timeout guard.
package axi_lite_resp_timeout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESP,
    ST_ERR,
    ST_DRAIN
  } ch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } addr_chan_lite_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_lite_t;

  typedef struct packed {
    axi_pkg::resp_t resp;
  } b_chan_lite_t;

  typedef struct packed {
    logic [31:0]    data;
    axi_pkg::resp_t resp;
  } r_chan_lite_t;

  typedef struct packed {
    addr_chan_lite_t aw;
    logic            aw_valid;
    w_chan_lite_t    w;
    logic            w_valid;
    logic            b_ready;
    addr_chan_lite_t ar;
    logic            ar_valid;
    logic            r_ready;
  } req_lite_t;

  typedef struct packed {
    logic         aw_ready;
    logic         w_ready;
    b_chan_lite_t b;
    logic         b_valid;
    logic         ar_ready;
    r_chan_lite_t r;
    logic         r_valid;
  } rsp_lite_t;

endpackage

// File: rtl/axi_pkg.sv
// Shared AXI response encodings used by the AXI4-Lite blocks.
package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_timeout_ch.sv
// One direction of the response-timeout guard: tracks request handshakes, waits for the
// response, and substitutes an error response (then drains the late one) on expiry.
module axi_lite_timeout_ch
  import axi_lite_resp_timeout_pkg::*;
#(
  parameter int unsigned TimeoutCycles  = 256,
  parameter bit          TwoReqChannels = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic slv_a_valid,
  output logic slv_a_ready,
  output logic mst_a_valid,
  input  logic mst_a_ready,
  input  logic slv_b_valid,
  output logic slv_b_ready,
  output logic mst_b_valid,
  input  logic mst_b_ready,
  output logic slv_rsp_valid,
  input  logic slv_rsp_ready,
  input  logic mst_rsp_valid,
  output logic mst_rsp_ready,
  output logic rsp_err,
  output logic timeout
);

  localparam int unsigned      CntWidth = $clog2(TimeoutCycles);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  ch_state_e             state_q, state_d;
  logic [CntWidth-1:0]   cnt_q;
  logic                  a_done_q, b_done_q, late_seen_q;
  logic                  a_fire, b_fire, a_complete, b_complete, start_resp, expire;

  assign a_fire     = mst_a_valid & mst_a_ready;
  assign b_fire     = mst_b_valid & mst_b_ready;
  assign a_complete = a_done_q | a_fire;
  // With a single request channel the second half counts as always complete.
  assign b_complete = !TwoReqChannels | b_done_q | b_fire;
  assign start_resp = (state_q == ST_IDLE) & a_complete & b_complete;
  assign expire     = (cnt_q == CntLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_resp) state_d = ST_RESP;
      ST_RESP: begin
        if (mst_rsp_valid && slv_rsp_ready) state_d = ST_IDLE;
        else if (!mst_rsp_valid && expire)  state_d = ST_ERR;
      end
      ST_ERR: begin
        if (slv_rsp_ready) state_d = (late_seen_q || mst_rsp_valid) ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: if (mst_rsp_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    slv_a_ready   = 1'b0;
    mst_a_valid   = 1'b0;
    slv_b_ready   = 1'b0;
    mst_b_valid   = 1'b0;
    slv_rsp_valid = 1'b0;
    mst_rsp_ready = 1'b0;
    rsp_err       = 1'b0;
    timeout       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mst_a_valid   = slv_a_valid & ~a_done_q;
        slv_a_ready   = mst_a_ready & ~a_done_q;
        mst_b_valid   = slv_b_valid & ~b_done_q;
        slv_b_ready   = mst_b_ready & ~b_done_q;
        slv_rsp_valid = mst_rsp_valid;
        mst_rsp_ready = slv_rsp_ready;
      end
      ST_RESP: begin
        slv_rsp_valid = mst_rsp_valid;
        mst_rsp_ready = slv_rsp_ready;
        timeout       = !mst_rsp_valid && expire;
      end
      ST_ERR: begin
        slv_rsp_valid = 1'b1;
        mst_rsp_ready = 1'b1;
        rsp_err       = 1'b1;
      end
      ST_DRAIN: mst_rsp_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      late_seen_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      a_done_q    <= start_resp ? 1'b0 : (a_done_q | a_fire);
      b_done_q    <= start_resp ? 1'b0 : (b_done_q | b_fire);
      late_seen_q <= (state_q == ST_ERR) & (late_seen_q | mst_rsp_valid);
      // Counter only runs while waiting; it stops at the expiry value rather than wrapping.
      if (state_q != ST_RESP)                    cnt_q <= '0;
      else if (!mst_rsp_valid && cnt_q != '1)    cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_resp_timeout.sv
// AXI4-Lite response-timeout guard: pass-through with SLVERR substitution when a peripheral
// fails to answer B or R in time. Only struct field routing lives here.
module axi_lite_resp_timeout
  import axi_pkg::*;
  import axi_lite_resp_timeout_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256,
  parameter type axi_lite_req_t = req_lite_t,
  parameter type axi_lite_rsp_t = rsp_lite_t
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  axi_lite_req_t slv_req_i,
  output axi_lite_rsp_t slv_resp_o,
  output axi_lite_req_t mst_req_o,
  input  axi_lite_rsp_t mst_resp_i,
  output logic          w_timeout_o,
  output logic          r_timeout_o
);

  logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready, w_err;
  logic ar_valid, ar_ready, r_valid, r_ready, r_err;
  logic rd_unused_b_ready, rd_unused_b_valid;

  axi_lite_timeout_ch #(
    .TimeoutCycles (TimeoutCycles),
    .TwoReqChannels(1'b1)
  ) i_write (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .slv_a_valid  (slv_req_i.aw_valid),
    .slv_a_ready  (aw_ready),
    .mst_a_valid  (aw_valid),
    .mst_a_ready  (mst_resp_i.aw_ready),
    .slv_b_valid  (slv_req_i.w_valid),
    .slv_b_ready  (w_ready),
    .mst_b_valid  (w_valid),
    .mst_b_ready  (mst_resp_i.w_ready),
    .slv_rsp_valid(b_valid),
    .slv_rsp_ready(slv_req_i.b_ready),
    .mst_rsp_valid(mst_resp_i.b_valid),
    .mst_rsp_ready(b_ready),
    .rsp_err      (w_err),
    .timeout      (w_timeout_o)
  );

  axi_lite_timeout_ch #(
    .TimeoutCycles (TimeoutCycles),
    .TwoReqChannels(1'b0)
  ) i_read (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .slv_a_valid  (slv_req_i.ar_valid),
    .slv_a_ready  (ar_ready),
    .mst_a_valid  (ar_valid),
    .mst_a_ready  (mst_resp_i.ar_ready),
    .slv_b_valid  (1'b0),
    .slv_b_ready  (rd_unused_b_ready),
    .mst_b_valid  (rd_unused_b_valid),
    .mst_b_ready  (1'b0),
    .slv_rsp_valid(r_valid),
    .slv_rsp_ready(slv_req_i.r_ready),
    .mst_rsp_valid(mst_resp_i.r_valid),
    .mst_rsp_ready(r_ready),
    .rsp_err      (r_err),
    .timeout      (r_timeout_o)
  );

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = aw_valid;
    mst_req_o.w_valid  = w_valid;
    mst_req_o.b_ready  = b_ready;
    mst_req_o.ar_valid = ar_valid;
    mst_req_o.r_ready  = r_ready;

    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b_valid  = b_valid;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.r_valid  = r_valid;
    // Substituted error responses are constant so they stay stable under back-pressure.
    if (w_err) slv_resp_o.b.resp = RESP_SLVERR;
    if (r_err) begin
      slv_resp_o.r.data = '0;
      slv_resp_o.r.resp = RESP_SLVERR;
    end
  end

endmodule
